mc_chroma_ref_fetch: RTL and testbench

- Feeder for the chroma fractional interpolator.
- Reads chroma reference rows from the reference-window SRAM, which has 1-cycle read latency.
- Streams 3 horizontally adjacent pixels per cycle (ref_valid_o, refuv_p0..p2_o), one 2-pixel-wide output strip at a time.
- Pulses end_oneblk_o between strips so the interpolator's row-history counter restarts for each strip.

---
 rtl/mc_chroma_ref_fetch.sv | 197 +++++++++++++++++++
 tb/tb_mc_chroma_ref_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mc_chroma_ref_fetch.sv
`default_nettype none
// ============================================================================
// mc_chroma_ref_fetch : streams 3-pixel chroma taps, one 2-wide strip at a time.
// Option macro MC_CHROMA_FETCH_CLIP_EN clamps columns at REF_PIX-1.  Rev 1.0
// ============================================================================

module mc_chroma_ref_fetch #(
  parameter int BIT_DEPTH = 8,
  parameter int REF_PIX   = 16,
  parameter int AW        = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [1:0]                   blk_w_i,
  input  logic [1:0]                   blk_h_i,
  input  logic [3:0]                   x0_i,
  input  logic [AW-1:0]                y0_i,
  input  logic [2:0]                   fracx_i,
  input  logic [2:0]                   fracy_i,
  output logic [2:0]                   fracx_o,
  output logic [2:0]                   fracy_o,
  output logic                         ref_rd_en_o,
  output logic [AW-1:0]                ref_rd_addr_o,
  input  logic [REF_PIX*BIT_DEPTH-1:0] ref_rdata_i,
  output logic                         ref_valid_o,
  output logic [BIT_DEPTH-1:0]         refuv_p0_o,
  output logic [BIT_DEPTH-1:0]         refuv_p1_o,
  output logic [BIT_DEPTH-1:0]         refuv_p2_o,
  output logic                         end_oneblk_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int IW = $clog2(REF_PIX);
  localparam int CW = IW + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [3:0]           r_q, r_d;
  logic [1:0]           s_q, s_d;
  logic                 drn_q, drn_d;
  logic [1:0]           blk_w_q, blk_h_q;
  logic [3:0]           x0_q;
  logic [AW-1:0]        y0_q;
  logic [2:0]           fracx_q, fracy_q;
  logic                 dvld_q, vld_q;
  logic [BIT_DEPTH-1:0] pix_q [3];

  logic [3:0]           w_h_last;
  logic [1:0]           w_s_last;
  logic                 w_start;
  logic [CW-1:0]        w_col;
  logic [BIT_DEPTH-1:0] w_row [REF_PIX];
  logic [BIT_DEPTH-1:0] w_pix [3];

  assign w_start = (state_q == S_IDLE) && start_i;

  // Last row index equals H (H+1 rows per strip); last strip index is W/2-1.
  always_comb begin
    case (blk_h_q)
      2'd0:    w_h_last = 4'd2;
      2'd1:    w_h_last = 4'd4;
      default: w_h_last = 4'd8;
    endcase
    case (blk_w_q)
      2'd0:    w_s_last = 2'd0;
      2'd1:    w_s_last = 2'd1;
      default: w_s_last = 2'd3;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      s_q     <= '0;
      drn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      drn_q   <= drn_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_w_q <= '0;
      blk_h_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      fracx_q <= '0;
      fracy_q <= '0;
    end else if (w_start) begin
      blk_w_q <= blk_w_i;
      blk_h_q <= blk_h_i;
      x0_q    <= x0_i;
      y0_q    <= y0_i;
      fracx_q <= fracx_i;
      fracy_q <= fracy_i;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_READ;
          r_d     = '0;
          s_d     = '0;
        end
      end
      S_READ: begin
        if (r_q == w_h_last) begin
          state_d = S_DRAIN;
          drn_d   = 1'b0;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (drn_q) state_d = S_END;
        else       drn_d   = 1'b1;
      end
      S_END: state_d = S_GAP;
      S_GAP: begin
        if (s_q == w_s_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
          s_d     = s_q + 2'd1;
          r_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ref_rd_en_o   = (state_q == S_READ);
    ref_rd_addr_o = ref_rd_en_o ? (y0_q + AW'(r_q)) : '0;
    end_oneblk_o  = (state_q == S_END);
    busy_o        = (state_q != S_IDLE);
    done_o        = (state_q == S_GAP) && (s_q == w_s_last);
  end

  assign w_col = CW'(x0_q) + CW'({s_q, 1'b0});

  for (genvar k = 0; k < REF_PIX; k++) begin : g_row
    assign w_row[k] = ref_rdata_i[k*BIT_DEPTH +: BIT_DEPTH];
  end

  for (genvar j = 0; j < 3; j++) begin : g_tap
    logic [CW-1:0] w_sum;
    logic [IW-1:0] w_idx;
    assign w_sum = w_col + CW'(j);
`ifdef MC_CHROMA_FETCH_CLIP_EN
    assign w_idx = (w_sum > CW'(REF_PIX-1)) ? IW'(REF_PIX-1) : w_sum[IW-1:0];
`else
    assign w_idx = IW'(w_sum % CW'(REF_PIX));
`endif
    assign w_pix[j] = w_row[w_idx];
  end

  // Read data lands one cycle after the request; taps are registered once more.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dvld_q <= 1'b0;
      vld_q  <= 1'b0;
      for (int j = 0; j < 3; j++) pix_q[j] <= '0;
    end else begin
      dvld_q <= (state_q == S_READ);
      vld_q  <= dvld_q;
      for (int j = 0; j < 3; j++) pix_q[j] <= dvld_q ? w_pix[j] : '0;
    end
  end

  assign ref_valid_o = vld_q;
  assign refuv_p0_o  = pix_q[0];
  assign refuv_p1_o  = pix_q[1];
  assign refuv_p2_o  = pix_q[2];
  assign fracx_o     = fracx_q;
  assign fracy_o     = fracy_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_chroma_ref_fetch.sv
`default_nettype none
// ============================================================================
// tb_mc_chroma_ref_fetch : random and directed blocks against a per-cycle event model.
// Rev 1.0
// ============================================================================

module tb_mc_chroma_ref_fetch;

  localparam int BD = 8;
  localparam int RP = 16;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     blk_w = '0, blk_h = '0;
  logic [3:0]     x0 = '0;
  logic [AW-1:0]  y0 = '0;
  logic [2:0]     fx = '0, fy = '0;
  logic [2:0]     fracx_o, fracy_o;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [RP*BD-1:0] rdata = '0;
  logic           vld, eob, busy, done;
  logic [BD-1:0]  p0, p1, p2;

  logic [RP*BD-1:0] mem [2**AW];

  int n_checks = 0;
  int n_fail   = 0;

  mc_chroma_ref_fetch #(.BIT_DEPTH(BD), .REF_PIX(RP), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .blk_w_i(blk_w), .blk_h_i(blk_h), .x0_i(x0), .y0_i(y0),
    .fracx_i(fx), .fracy_i(fy), .fracx_o(fracx_o), .fracy_o(fracy_o),
    .ref_rd_en_o(rd_en), .ref_rd_addr_o(rd_addr), .ref_rdata_i(rdata),
    .ref_valid_o(vld), .refuv_p0_o(p0), .refuv_p1_o(p1), .refuv_p2_o(p2),
    .end_oneblk_o(eob), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Reference-window SRAM with one cycle of read latency.
  always @(posedge clk) if (rd_en) rdata <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2**AW; i++)
      for (int n = 0; n < RP; n++) mem[i][n*BD +: BD] = BD'($urandom);
  endtask

  function automatic int col_of(input int c);
`ifdef MC_CHROMA_FETCH_CLIP_EN
    return (c > RP-1) ? RP-1 : c;
`else
    return c % RP;
`endif
  endfunction

  // Builds the expected per-cycle trace (cycle 1 = first READ), drives the
  // request and compares every cycle; optional stray start and mid-block reset.
  task automatic run_block(input int w, input int h, input int bx, input int by,
                           input int bfx, input int bfy, input int inj_k,
                           input int rst_k, output int n_vld);
    int e_rd[64], e_addr[64], e_vld[64], e_end[64], e_done[64], e_busy[64];
    int e_p[64][3];
    int ns, hh, per, total, len, base, row;
    logic [RP*BD-1:0] rw;
    bit in_rst;
    logic [BD-1:0] got_p[3];
    ns = (w == 0) ? 1 : (w == 1) ? 2 : 4;
    hh = (h == 0) ? 2 : (h == 1) ? 4 : 8;
    per = hh + 5;
    total = ns * per;
    len = total + 3;
    for (int k = 0; k < 64; k++) begin
      e_rd[k] = 0; e_addr[k] = 0; e_vld[k] = 0; e_end[k] = 0; e_done[k] = 0; e_busy[k] = 0;
      for (int j = 0; j < 3; j++) e_p[k][j] = 0;
    end
    for (int s = 0; s < ns; s++) begin
      base = 1 + s * per;
      for (int r = 0; r <= hh; r++) begin
        row = (by + r) % (2**AW);
        rw = mem[row];
        e_rd[base+r] = 1;
        e_addr[base+r] = row;
        e_vld[base+2+r] = 1;
        for (int j = 0; j < 3; j++) e_p[base+2+r][j] = int'(rw[col_of(bx + 2*s + j)*BD +: BD]);
      end
      e_end[base+hh+3] = 1;
      if (s == ns-1) e_done[base+hh+4] = 1;
    end
    for (int k = 1; k <= total; k++) e_busy[k] = 1;

    n_vld = 0;
    @(negedge clk);
    blk_w = 2'(w); blk_h = 2'(h); x0 = 4'(bx); y0 = AW'(by); fx = 3'(bfx); fy = 3'(bfy);
    start = 1'b1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      in_rst = (rst_k != 0) && (k > rst_k);
      got_p[0] = p0; got_p[1] = p1; got_p[2] = p2;
      check($sformatf("rd_en@%0d", k), 32'(rd_en), in_rst ? 0 : e_rd[k]);
      if (e_rd[k] != 0 && !in_rst) check($sformatf("addr@%0d", k), 32'(rd_addr), e_addr[k]);
      check($sformatf("valid@%0d", k), 32'(vld), in_rst ? 0 : e_vld[k]);
      if (e_vld[k] != 0 && !in_rst)
        for (int j = 0; j < 3; j++) check($sformatf("p%0d@%0d", j, k), 32'(got_p[j]), e_p[k][j]);
      check($sformatf("end@%0d", k), 32'(eob), in_rst ? 0 : e_end[k]);
      check($sformatf("done@%0d", k), 32'(done), in_rst ? 0 : e_done[k]);
      check($sformatf("busy@%0d", k), 32'(busy), in_rst ? 0 : e_busy[k]);
      check($sformatf("fracx@%0d", k), 32'(fracx_o), in_rst ? 0 : bfx);
      check($sformatf("fracy@%0d", k), 32'(fracy_o), in_rst ? 0 : bfy);
      n_vld += int'(vld);
      start = (k == inj_k);
      if (k == inj_k) begin
        x0 = 4'(bx) ^ 4'hA; y0 = AW'(by + 9); fx = 3'(bfx) ^ 3'h5; fy = 3'(bfy) ^ 3'h3;
        blk_w = 2'(w) ^ 2'b01; blk_h = 2'(h) ^ 2'b10;
      end
      if (k == rst_k) rst = 1'b1;
    end
    start = 1'b0;
    if (rst_k != 0) begin
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    int nv;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(vld), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_end", 32'(eob), 0);
    check("rst_fracx", 32'(fracx_o), 0);
    check("rst_p0", 32'(p0), 0);
    rst = 1'b0;

    // Row k holds pixel n = 16k+n: 2x2 at x0=0, y0=3 gives (48,49,50),(64,65,66),(80,81,82).
    for (int i = 0; i < 2**AW; i++)
      for (int n = 0; n < RP; n++) mem[i][n*BD +: BD] = BD'(16*i + n);
    run_block(0, 0, 0, 3, 1, 2, 0, 0, nv);
    check("tp2x2_nvalid", 32'(nv), 3);

    fill_random();
    run_block(2, 2, 15, 7, 3, 6, 0, 0, nv);   // 8x8, right-edge columns in strip 3
    check("tp8x8_nvalid", 32'(nv), 36);
    run_block(3, 3, 4, 12, 7, 0, 0, 0, nv);   // code 3 behaves as 8
    check("tp8x8c3_nvalid", 32'(nv), 36);
    run_block(1, 1, 5, 30, 2, 5, 0, 0, nv);   // row wrap 30,31,0,1,2
    run_block(1, 1, 9, 2, 4, 1, 6, 0, nv);    // stray start mid-block
    run_block(0, 2, 3, 20, 6, 3, 13, 0, nv);  // stray start in the done cycle
    run_block(2, 2, 1, 11, 5, 5, 0, 23, nv);  // reset in DRAIN of strip 1
    run_block(2, 2, 6, 25, 1, 7, 0, 0, nv);
    check("post_rst_nvalid", 32'(nv), 36);

    for (int t = 0; t < 12; t++) begin
      fill_random();
      run_block(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, 0, nv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
